cart_mem_sequencer: RTL
=======================

Name: cart_mem_sequencer

Overview:
- Sits directly downstream of the cartridge mapper mux in the top-level SNES core.
- Consumes the mapper's level-style ROM and BSRAM strobes (ROM_ADDR/CE_N/OE_N/WE_N/WORD, BSRAM_ADDR/CE_N/OE_N/WE_N) and converts them into discrete request/acknowledge transactions on a single shared external-memory port (SDRAM controller).
- Returns held read data on rom_q/bsram_q.
- Arbitrates ROM vs BSRAM and issues exactly one memory transaction per distinct access.

Parameters:
- BSRAM_BASE, 25'h1800000, byte address in external memory where BSRAM region starts (bsram_addr is added to it).
- ROM_BASE, 25'h0000000, byte address where ROM region starts.

Ports:
- mclk  in  1  master clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- rom_addr  in  24  ROM byte address from mapper
- rom_d  in  16  ROM write data (BS-X flash/PSRAM)
- rom_ce_n  in  1  ROM chip enable, active low
- rom_oe_n  in  1  ROM read strobe, active low
- rom_we_n  in  1  ROM write strobe, active low
- rom_word  in  1  1 = 16-bit access, 0 = byte access
- rom_q  out  16  ROM read data, held until next ROM read completes
- bsram_addr  in  20  BSRAM byte address
- bsram_d  in  8  BSRAM write data
- bsram_ce_n  in  1  BSRAM chip enable, active low
- bsram_oe_n  in  1  BSRAM read strobe
- bsram_we_n  in  1  BSRAM write strobe
- bsram_q  out  8  BSRAM read data, held
- mem_req  out  1  transaction request, held high until mem_ack
- mem_we  out  1  1 = write transaction
- mem_addr  out  25  byte address of transaction
- mem_din  out  16  write data
- mem_be  out  2  byte enables, [1] = odd byte
- mem_ack  in  1  one-cycle pulse: transaction done; read data valid this cycle
- mem_dout  in  16  read data from memory
- busy  out  1  high while any request pending or in flight

Behaviour:
- Reset (async, rst_n low): mem_req=0, mem_we=0, mem_addr=0, mem_din=0, mem_be=0, rom_q=0, bsram_q=0, busy=0. State=IDLE, both pending flags cleared, last-access registers invalidated. Reset mid-transaction drops mem_req immediately; a late mem_ack after reset is ignored (state IDLE).
- Access detection per channel:
  - Active = ce_n low AND (oe_n low XOR we_n low).
  - Both oe_n and we_n low is illegal and treated as inactive.
  - A new access is flagged when active AND (previous cycle inactive OR address OR direction OR rom_word changed vs the registered previous sample). It sets that channel's pending flag and latches addr/data/dir/word.
  - A new access while the channel is already pending overwrites the latched parameters (most recent wins). One transaction total.
- FSM:
  - IDLE: if any pending → ISSUE, selecting BSRAM over ROM when both are pending.
  - ISSUE: drive mem_req=1 with the latched fields; clear the selected pending flag; → WAIT.
  - WAIT: hold mem_req and all fields stable until mem_ack; on mem_ack drop mem_req, capture read data → IDLE.
  - Minimum turnaround: 1 idle cycle between transactions.
  - A new access detected during WAIT sets pending and is serviced after return to IDLE.
- Address/width:
  - ROM: mem_addr = ROM_BASE + rom_addr. Word access forces mem_addr[0]=0 and mem_be=2'b11.
  - ROM byte access: mem_be = addr[0] ? 2'b10 : 2'b01; write data = {rom_d[7:0], rom_d[7:0]}.
  - BSRAM: mem_addr = BSRAM_BASE + bsram_addr, always byte; mem_din = {bsram_d, bsram_d}.
  - Additions truncate to 25 bits.
- Read capture:
  - ROM word → rom_q = mem_dout.
  - ROM byte → rom_q = {8'h00, selected byte}, where the selected byte is mem_dout[15:8] if addr[0]=1 else [7:0].
  - BSRAM → bsram_q = selected byte.
  - Writes leave rom_q/bsram_q unchanged.
- busy = (state != IDLE) | rom_pending | bsram_pending.

Optional Feature:
- Macro CART_MEM_WORD_CACHE_EN.
- Defined:
  - One-entry ROM read cache (word address, 16-bit data, valid bit).
  - A ROM read whose word address matches a valid entry completes without a memory transaction: rom_q updated the cycle after detection, no pending flag set.
  - Every ROM read ack refills the entry.
  - A ROM write to the cached word invalidates it.
  - Reset invalidates.
- Undefined: every ROM read issues a transaction.

Test Plan:
- ROM word read rom_addr=24'h00_8000, mem_ack after 4 cycles with mem_dout=16'hA55A → one mem_req with mem_addr=25'h0008000, mem_be=2'b11, mem_we=0; rom_q=16'hA55A after ack.
- ROM byte read addr=24'h000001, mem_dout=16'h1234 → mem_be=2'b10; rom_q=16'h0012.
- BSRAM write addr=20'h00010, d=8'h5C, strobes held low 20 cycles → exactly one transaction: mem_addr=25'h1800010, mem_din=16'h5C5C, mem_be=2'b01, mem_we=1.
- Simultaneous new ROM read and BSRAM read in the same cycle → BSRAM transaction first, ROM second after ack plus 1 idle cycle; busy high throughout, low after second ack.
- rst_n asserted while mem_req=1 in WAIT → mem_req=0 asynchronously, all outputs 0; a subsequent mem_ack pulse produces no state change.
- With CART_MEM_WORD_CACHE_EN: two consecutive reads of 24'h000100 → second issues no mem_req; rom_q equals the first data. A write to 24'h000101 followed by a read of 24'h000100 → mem_req issued.

Source files
------------

// File: rtl/cart_mem_sequencer_if.sv
// cart_mem_sequencer_if: shared external-memory request/acknowledge port.
interface cart_mem_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic [15:0] mem_dout;
    modport master (output mem_req, mem_we, mem_addr, mem_din, mem_be, input mem_ack, mem_dout);
    modport slave  (input mem_req, mem_we, mem_addr, mem_din, mem_be, output mem_ack, mem_dout);
endinterface

// File: rtl/cart_mem_sequencer.sv
// cart_mem_sequencer: turns level-style ROM/BSRAM strobes into single memory transactions.
// Optional one-entry ROM read cache enabled by CART_MEM_WORD_CACHE_EN.
module cart_mem_sequencer #(
    parameter logic [24:0] BSRAM_BASE = 25'h1800000,
    parameter logic [24:0] ROM_BASE   = 25'h0000000
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic [23:0]                  rom_addr,
    input  logic [15:0]                  rom_d,
    input  logic                         rom_ce_n,
    input  logic                         rom_oe_n,
    input  logic                         rom_we_n,
    input  logic                         rom_word,
    output logic [15:0]                  rom_q,
    input  logic [19:0]                  bsram_addr,
    input  logic [7:0]                   bsram_d,
    input  logic                         bsram_ce_n,
    input  logic                         bsram_oe_n,
    input  logic                         bsram_we_n,
    output logic [7:0]                   bsram_q,
    cart_mem_sequencer_if.master         mem,
    output logic                         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      state_q;
    logic        rom_act_q, rom_pwe_q, rom_pword_q, bs_act_q, bs_pwe_q;
    logic [23:0] rom_paddr_q, rom_a_q;
    logic [19:0] bs_paddr_q, bs_a_q;
    logic        rom_pend_q, rom_we_q, rom_word_q, bs_pend_q, bs_we_q;
    logic [15:0] rom_d_q;
    logic [7:0]  bs_d_q, ack_byte;
    logic        sel_q, cur_word_q, cur_a0_q;
    logic        rom_act, rom_new, rom_set, bs_act, bs_new;
    logic [24:0] rom_sum, bs_sum;
    // a strobe pair with both oe_n and we_n low is illegal and ignored
    assign rom_act  = !rom_ce_n && (!rom_oe_n ^ !rom_we_n);
    assign bs_act   = !bsram_ce_n && (!bsram_oe_n ^ !bsram_we_n);
    assign rom_new  = rom_act && (!rom_act_q || rom_addr != rom_paddr_q || !rom_we_n != rom_pwe_q || rom_word != rom_pword_q);
    assign bs_new   = bs_act && (!bs_act_q || bsram_addr != bs_paddr_q || !bsram_we_n != bs_pwe_q);
    assign rom_sum  = ROM_BASE + {1'b0, rom_a_q};
    assign bs_sum   = BSRAM_BASE + {5'b0, bs_a_q};
    assign ack_byte = cur_a0_q ? mem.mem_dout[15:8] : mem.mem_dout[7:0];
    assign busy     = state_q != IDLE || rom_pend_q || bs_pend_q;
`ifdef CART_MEM_WORD_CACHE_EN
    logic        cache_v_q, rom_hit;
    logic [22:0] cache_wa_q, cur_wa_q;
    logic [15:0] cache_d_q;
    assign rom_hit = rom_new && rom_we_n && cache_v_q && cache_wa_q == rom_addr[23:1];
    assign rom_set = rom_new && !rom_hit;
`else
    assign rom_set = rom_new;
`endif
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
            mem.mem_be   <= '0;
            rom_q        <= '0;
            bsram_q      <= '0;
            rom_act_q    <= 1'b0;
            rom_pwe_q    <= 1'b0;
            rom_pword_q  <= 1'b0;
            rom_paddr_q  <= '0;
            bs_act_q     <= 1'b0;
            bs_pwe_q     <= 1'b0;
            bs_paddr_q   <= '0;
            rom_pend_q   <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_word_q   <= 1'b0;
            rom_a_q      <= '0;
            rom_d_q      <= '0;
            bs_pend_q    <= 1'b0;
            bs_we_q      <= 1'b0;
            bs_a_q       <= '0;
            bs_d_q       <= '0;
            sel_q        <= 1'b0;
            cur_word_q   <= 1'b0;
            cur_a0_q     <= 1'b0;
`ifdef CART_MEM_WORD_CACHE_EN
            cache_v_q    <= 1'b0;
            cache_wa_q   <= '0;
            cache_d_q    <= '0;
            cur_wa_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (rom_pend_q || bs_pend_q) begin
                    state_q <= ISSUE;
                    sel_q   <= bs_pend_q;
                end
                ISSUE: begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= sel_q ? bs_we_q : rom_we_q;
                    mem.mem_addr <= sel_q ? bs_sum : {rom_sum[24:1], rom_sum[0] & !rom_word_q};
                    mem.mem_din  <= sel_q ? {bs_d_q, bs_d_q} : rom_word_q ? rom_d_q : {2{rom_d_q[7:0]}};
                    mem.mem_be   <= (!sel_q && rom_word_q) ? 2'b11 : (sel_q ? bs_a_q[0] : rom_a_q[0]) ? 2'b10 : 2'b01;
                    cur_a0_q     <= sel_q ? bs_a_q[0] : rom_a_q[0];
                    cur_word_q   <= !sel_q && rom_word_q;
`ifdef CART_MEM_WORD_CACHE_EN
                    cur_wa_q     <= rom_a_q[23:1];
`endif
                    if (sel_q) bs_pend_q <= 1'b0;
                    else rom_pend_q <= 1'b0;
                    state_q      <= WAIT;
                end
                WAIT: if (mem.mem_ack) begin
                    mem.mem_req <= 1'b0;
                    state_q     <= IDLE;
                    if (!mem.mem_we && sel_q) bsram_q <= ack_byte;
                    if (!mem.mem_we && !sel_q) rom_q <= cur_word_q ? mem.mem_dout : {8'h00, ack_byte};
`ifdef CART_MEM_WORD_CACHE_EN
                    if (!sel_q && !mem.mem_we) begin
                        cache_v_q  <= 1'b1;
                        cache_wa_q <= cur_wa_q;
                        cache_d_q  <= mem.mem_dout;
                    end
                    if (!sel_q && mem.mem_we && cur_wa_q == cache_wa_q) cache_v_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
            rom_act_q   <= rom_act;
            rom_pwe_q   <= !rom_we_n;
            rom_pword_q <= rom_word;
            rom_paddr_q <= rom_addr;
            bs_act_q    <= bs_act;
            bs_pwe_q    <= !bsram_we_n;
            bs_paddr_q  <= bsram_addr;
            // placed after the FSM so a fresh access re-arms a flag being cleared by ISSUE
            if (rom_set) begin
                rom_pend_q <= 1'b1;
                rom_we_q   <= !rom_we_n;
                rom_word_q <= rom_word;
                rom_a_q    <= rom_addr;
                rom_d_q    <= rom_d;
            end
            if (bs_new) begin
                bs_pend_q <= 1'b1;
                bs_we_q   <= !bsram_we_n;
                bs_a_q    <= bsram_addr;
                bs_d_q    <= bsram_d;
            end
`ifdef CART_MEM_WORD_CACHE_EN
            if (rom_hit) rom_q <= rom_word ? cache_d_q : {8'h00, rom_addr[0] ? cache_d_q[15:8] : cache_d_q[7:0]};
            if (rom_new && !rom_we_n && rom_addr[23:1] == cache_wa_q) cache_v_q <= 1'b0;
`endif
        end
    end
endmodule
